// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and call/return sequencer for a ROM-fed datapath.
// Decodes the instruction at oPC combinationally and picks the next fetch address
// from jump, conditional branch, call and return opcodes. Calls and returns use
// an 8-deep return stack.
// Optional feature: define PC_NOP_DELAY_EN so that NOP holds the PC for a
// programmable number of cycles. Without the macro, NOP is a plain advance.
// Opcode encoding mirrors the ROM opcode table: NOP=0 ADD=1 SUB=2 STO=3 BLE=4
// BGE=5 JMP=6 CALL=7 RET=8 SMUL=9.
module pc_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [27:0] iInstruction,
  input  logic [15:0] iSrc1Value,
  input  logic [15:0] iSrc0Value,
  output logic [15:0] oPC,
  output logic        oExecute,
  output logic        oStackError,
  output logic        oNopWait
);

  localparam int unsigned PC_W        = 16;
  localparam int unsigned SP_W        = 4;
  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned TGT_W       = 8;
  localparam int unsigned NOP_W       = 24;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_BLE  = 4'd4;
  localparam logic [3:0] OP_BGE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_CALL = 4'd7;
  localparam logic [3:0] OP_RET  = 4'd8;

  logic [3:0]       opcode;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_next;
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_next;
  logic [IDX_W-1:0] top_idx;
  logic             stack_full;
  logic             stack_empty;
  logic             push;
  logic             err_set;
  logic             ble_take;
  logic             bge_take;
  logic [PC_W-1:0]  ret_stack [STACK_DEPTH];

`ifdef PC_NOP_DELAY_EN
  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           state;
  state_t           state_next;
  logic [NOP_W-1:0] cnt;
  logic [NOP_W-1:0] cnt_next;
  logic [NOP_W-1:0] nop_len;

  assign nop_len  = iInstruction[NOP_W-1:0];
  assign oNopWait = (state == ST_WAIT);
`else
  // NOP literal field is only meaningful when the delay feature is built in.
  logic unused_nop_literal;
  assign unused_nop_literal = ^iInstruction[15:0];
  assign oNopWait = 1'b0;
`endif

  // Instruction field decode and branch comparisons.
  assign opcode      = iInstruction[27:24];
  assign target      = {8'h00, iInstruction[23:16]};
  assign pc_inc      = oPC + PC_W'(1);
  assign ble_take    = (iSrc1Value <= iSrc0Value);
  assign bge_take    = (iSrc1Value >= iSrc0Value);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign oExecute    = !Reset && !oNopWait;

  // Next PC, stack pointer and delay-state selection.
  always_comb begin
    pc_next = pc_inc;
    sp_next = sp;
    push    = 1'b0;
    err_set = 1'b0;
`ifdef PC_NOP_DELAY_EN
    state_next = state;
    cnt_next   = cnt;
    if (state == ST_WAIT) begin
      if (cnt == '0) begin
        state_next = ST_RUN;
        pc_next    = pc_inc;
      end else begin
        cnt_next = cnt - NOP_W'(1);
        pc_next  = oPC;
      end
    end else
`endif
    begin
      case (opcode)
`ifdef PC_NOP_DELAY_EN
        OP_NOP: begin
          if (nop_len != '0) begin
            pc_next    = oPC;
            cnt_next   = nop_len - NOP_W'(1);
            state_next = ST_WAIT;
          end
        end
`endif
        OP_JMP: pc_next = target;
        OP_BLE: if (ble_take) pc_next = target;
        OP_BGE: if (bge_take) pc_next = target;
        OP_CALL: begin
          pc_next = target;
          if (stack_full) begin
            err_set = 1'b1;
          end else begin
            push    = 1'b1;
            sp_next = sp + SP_W'(1);
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_set = 1'b1;
          end else begin
            pc_next = ret_stack[top_idx];
            sp_next = sp - SP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers: PC, stack pointer, sticky error and delay state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oPC         <= '0;
      sp          <= '0;
      oStackError <= 1'b0;
`ifdef PC_NOP_DELAY_EN
      state       <= ST_RUN;
      cnt         <= '0;
`endif
    end else begin
      oPC <= pc_next;
      sp  <= sp_next;
      if (err_set) oStackError <= 1'b1;
`ifdef PC_NOP_DELAY_EN
      state <= state_next;
      cnt   <= cnt_next;
`endif
    end
  end

  // Return-address storage; contents are irrelevant after reset so it is not cleared.
  always_ff @(posedge Clock) begin
    if (!Reset && push) ret_stack[sp[IDX_W-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives one instruction, queues the
// expected post-edge state, then pops and compares it one time unit after the edge.
module tb_pc_sequencer;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_BLE  = 4'd4;
  localparam logic [3:0] OP_BGE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_CALL = 4'd7;
  localparam logic [3:0] OP_RET  = 4'd8;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        err;
    logic        nwait;
    logic        exec;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [27:0] iInstruction;
  logic [15:0] iSrc1Value;
  logic [15:0] iSrc0Value;
  logic [15:0] oPC;
  logic        oExecute;
  logic        oStackError;
  logic        oNopWait;

  exp_t        sb [$];
  logic [15:0] rs [$];
  int          total  = 0;
  int          passed = 0;
  logic [15:0] pc_m;
  logic        err_m;

  pc_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iInstruction (iInstruction),
    .iSrc1Value   (iSrc1Value),
    .iSrc0Value   (iSrc0Value),
    .oPC          (oPC),
    .oExecute     (oExecute),
    .oStackError  (oStackError),
    .oNopWait     (oNopWait)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] t,
                                      input logic [7:0] a, input logic [7:0] b);
    return {op, t, a, b};
  endfunction

  function automatic logic [27:0] nop(input logic [23:0] n);
    return {OP_NOP, n};
  endfunction

  task automatic check(input string tag, input string fld, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s.%s: got %0h expected %0h", tag, fld, got, exp);
  endtask

  // Drive one cycle, queue expectations, and compare after the edge.
  task automatic step(input string tag, input logic [27:0] instr, input logic [15:0] s1,
                      input logic [15:0] s0, input logic rst, input logic [15:0] epc,
                      input logic eerr, input logic ewait);
    exp_t e;
    exp_t g;
    Reset        = rst;
    iInstruction = instr;
    iSrc1Value   = s1;
    iSrc0Value   = s0;
    e.tag   = tag;
    e.pc    = epc;
    e.err   = eerr;
    e.nwait = ewait;
    e.exec  = !rst && !ewait;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    g = sb.pop_front();
    check(g.tag, "pc",   oPC,                 g.pc);
    check(g.tag, "err",  16'(oStackError),    16'(g.err));
    check(g.tag, "wait", 16'(oNopWait),       16'(g.nwait));
    check(g.tag, "exec", 16'(oExecute),       16'(g.exec));
  endtask

  initial begin
    Reset        = 1'b1;
    iInstruction = '0;
    iSrc1Value   = '0;
    iSrc0Value   = '0;

    // Reset behaviour, including reset from a non-zero PC.
    step("rst0",  ins(OP_ADD, 8'd0, 8'd0, 8'd0), 16'd0, 16'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    step("rst1",  ins(OP_ADD, 8'd0, 8'd0, 8'd0), 16'd0, 16'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    step("jmp5",  ins(OP_JMP, 8'd5, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd5, 1'b0, 1'b0);
    step("rsta",  ins(OP_ADD, 8'd0, 8'd1, 8'd2), 16'd0, 16'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    step("rstb",  ins(OP_ADD, 8'd0, 8'd1, 8'd2), 16'd0, 16'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    step("inc1",  ins(OP_ADD, 8'd9, 8'd1, 8'd2), 16'd0, 16'd0, 1'b0, 16'd1, 1'b0, 1'b0);
    step("inc2",  ins(OP_ADD, 8'd9, 8'd1, 8'd2), 16'd0, 16'd0, 1'b0, 16'd2, 1'b0, 1'b0);

    // Branches, including unsigned extremes.
    step("ble_eq",  ins(OP_BLE, 8'd52, 8'd1, 8'd2), 16'd31,   16'd31,   1'b0, 16'd52, 1'b0, 1'b0);
    step("ble_nt",  ins(OP_BLE, 8'd99, 8'd1, 8'd2), 16'd32,   16'd31,   1'b0, 16'd53, 1'b0, 1'b0);
    step("ble_uns", ins(OP_BLE, 8'd7,  8'd1, 8'd2), 16'h0000, 16'hFFFF, 1'b0, 16'd7,  1'b0, 1'b0);
    step("bge_eq",  ins(OP_BGE, 8'd0,  8'd1, 8'd2), 16'd383,  16'd383,  1'b0, 16'd0,  1'b0, 1'b0);
    step("bge_nt",  ins(OP_BGE, 8'd9,  8'd1, 8'd2), 16'd1,    16'd2,    1'b0, 16'd1,  1'b0, 1'b0);
    step("bge_uns", ins(OP_BGE, 8'd9,  8'd1, 8'd2), 16'hFFFF, 16'h0000, 1'b0, 16'd9,  1'b0, 1'b0);

    // Single call/return.
    step("jmp7",  ins(OP_JMP,  8'd7,  8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd7,  1'b0, 1'b0);
    step("call",  ins(OP_CALL, 8'd50, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd50, 1'b0, 1'b0);
    step("jmp66", ins(OP_JMP,  8'd66, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd66, 1'b0, 1'b0);
    step("ret",   ins(OP_RET,  8'd0,  8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd8,  1'b0, 1'b0);

    // Eight nested calls, a ninth overflowing one, then eight returns.
    pc_m  = 16'd8;
    err_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] t;
      t = 8'(100 + i * 10);
      rs.push_back(pc_m + 16'd1);
      pc_m = {8'h00, t};
      step($sformatf("ncall%0d", i), ins(OP_CALL, t, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0,
           pc_m, err_m, 1'b0);
    end
    err_m = 1'b1;
    pc_m  = 16'd200;
    step("ovf", ins(OP_CALL, 8'd200, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, pc_m, err_m, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pc_m = rs.pop_back();
      step($sformatf("nret%0d", i), ins(OP_RET, 8'd0, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0,
           pc_m, err_m, 1'b0);
    end
    step("unf_sticky", ins(OP_RET, 8'd0, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd10, 1'b1, 1'b0);

    // Underflow from a clean state.
    step("rst_c",  ins(OP_ADD, 8'd0,  8'd0, 8'd0), 16'd0, 16'd0, 1'b1, 16'd0,  1'b0, 1'b0);
    step("jmp20",  ins(OP_JMP, 8'd20, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd20, 1'b0, 1'b0);
    step("unf",    ins(OP_RET, 8'd0,  8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd21, 1'b1, 1'b0);
    step("rst_d",  ins(OP_ADD, 8'd0,  8'd0, 8'd0), 16'd0, 16'd0, 1'b1, 16'd0,  1'b0, 1'b0);

`ifdef PC_NOP_DELAY_EN
    // NOP delay of three cycles, then a delay aborted by reset.
    step("jmp10a", ins(OP_JMP, 8'd10, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd10, 1'b0, 1'b0);
    step("nopw1",  nop(24'd3), 16'd0, 16'd0, 1'b0, 16'd10, 1'b0, 1'b1);
    step("nopw2",  nop(24'd3), 16'd0, 16'd0, 1'b0, 16'd10, 1'b0, 1'b1);
    step("nopw3",  nop(24'd3), 16'd0, 16'd0, 1'b0, 16'd10, 1'b0, 1'b1);
    step("nopend", nop(24'd3), 16'd0, 16'd0, 1'b0, 16'd11, 1'b0, 1'b0);
    step("jmp10b", ins(OP_JMP, 8'd10, 8'd0, 8'd0), 16'd0, 16'd0, 1'b0, 16'd10, 1'b0, 1'b0);
    step("nopa1",  nop(24'd3), 16'd0, 16'd0, 1'b0, 16'd10, 1'b0, 1'b1);
    step("nopa2",  nop(24'd3), 16'd0, 16'd0, 1'b0, 16'd10, 1'b0, 1'b1);
    step("noprst", nop(24'd3), 16'd0, 16'd0, 1'b1, 16'd0,  1'b0, 1'b0);
    step("nop0",   nop(24'd0), 16'd0, 16'd0, 1'b0, 16'd1,  1'b0, 1'b0);
`else
    // NOP is a single-cycle advance regardless of its literal.
    step("nop4000", nop(24'd4000),    16'd0, 16'd0, 1'b0, 16'd1, 1'b0, 1'b0);
    step("nopmax",  nop(24'hFFFFFF),  16'd0, 16'd0, 1'b0, 16'd2, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
